// File: rtl/apb_servo_array_if.sv
`default_nettype none
// ============================================================================
// Module  : apb_servo_array_if
// Brief   : APB3 bus bundle between the fabric master and the servo array.
// Rev     : 1.0  initial release
// ============================================================================
interface apb_servo_array_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_servo_array.sv
`default_nettype none
// ============================================================================
// Module  : apb_servo_array
// Brief   : APB3 slave driving NUM_CH servo PWM outputs with slew limiting,
//           dead-reckoning counters and hardware return-to-zero.
// Rev     : 1.0  initial release
// ============================================================================
module apb_servo_array #(
  parameter int NUM_CH      = 4,
  parameter int PWM_PERIOD  = 2000000,
  parameter int PW_NEUTRAL  = 150000,
  parameter int PW_FULL_FWD = 163000,
  parameter int PW_FULL_REV = 137000,
  parameter int PW_MIN      = 100000,
  parameter int PW_MAX      = 200000,
  parameter int SLEW_STEP   = 0
) (
  input  wire logic         PCLK,
  input  wire logic         PRESERN,
  apb_servo_array_if.slave  apb,
  output logic [NUM_CH-1:0] servo_pwm,
  output logic              irq
);

  localparam logic [31:0] c_last    = 32'(PWM_PERIOD - 1);
  localparam logic [31:0] c_neutral = 32'(PW_NEUTRAL);
  localparam logic [31:0] c_fwd     = 32'(PW_FULL_FWD);
  localparam logic [31:0] c_rev     = 32'(PW_FULL_REV);
  localparam logic [31:0] c_min     = 32'(PW_MIN);
  localparam logic [31:0] c_max     = 32'(PW_MAX);
  localparam logic [31:0] c_slew    = 32'(SLEW_STEP);

  logic [31:0]       tcnt_q;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0] irq_stat_q, irq_stat_d, set_irq, servo_q;
  logic [NUM_CH-1:0] ret_q, ret_d, zp_q, zp_d;
  logic [31:0]       tgt_q [NUM_CH];
  logic [31:0]       tgt_d [NUM_CH];
  logic [31:0]       cur_q [NUM_CH];
  logic [31:0]       cur_d [NUM_CH];
  logic [31:0]       fwd_q [NUM_CH];
  logic [31:0]       fwd_d [NUM_CH];
  logic [31:0]       rev_q [NUM_CH];
  logic [31:0]       rev_d [NUM_CH];

  logic [12:0] w_addr;
  logic [6:0]  w_blk, w_ch_idx;
  logic [5:0]  w_off;
  logic        w_is_ch, w_off_ok, w_glob, w_wr, w_bnd, w_unused;
  logic [31:0] w_rdata;

  assign w_addr   = apb.PADDR[12:0];
  assign w_blk    = w_addr[12:6];
  assign w_off    = w_addr[5:0];
  assign w_ch_idx = w_blk - 7'd4;
  assign w_is_ch  = (w_blk >= 7'd4) && (w_blk < 7'(NUM_CH + 4));
  assign w_off_ok = (w_off == 6'h00) || (w_off == 6'h04) || (w_off == 6'h08) ||
                    (w_off == 6'h0C) || (w_off == 6'h10) || (w_off == 6'h14);
  assign w_glob   = (w_addr == 13'h000) || (w_addr == 13'h004) || (w_addr == 13'h008);
  assign w_wr     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_bnd    = (tcnt_q == c_last);
  assign w_unused = ^apb.PADDR[31:13];

  assign apb.PRDATA  = w_rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = PRESERN & apb.PSEL & apb.PENABLE & ~(w_glob | (w_is_ch & w_off_ok));
  assign servo_pwm   = servo_q;
  assign irq         = |(irq_stat_q & irq_en_q);

  function automatic logic [31:0] clamp_pw(input logic [31:0] v);
    if (v < c_min) return c_min;
    if (v > c_max) return c_max;
    return v;
  endfunction

  function automatic logic [31:0] slew_next(input logic [31:0] cur, input logic [31:0] tgt);
    if (c_slew == 32'd0) return tgt;
    if (tgt > cur) return ((tgt - cur) > c_slew) ? cur + c_slew : tgt;
    return ((cur - tgt) > c_slew) ? cur - c_slew : tgt;
  endfunction

  always_comb begin
    ch_en_d    = (w_wr && w_addr == 13'h000) ? apb.PWDATA[NUM_CH-1:0] : ch_en_q;
    irq_en_d   = (w_wr && w_addr == 13'h004) ? apb.PWDATA[NUM_CH-1:0] : irq_en_q;
    set_irq    = '0;
    irq_stat_d = irq_stat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      fwd_d[i] = fwd_q[i];
      rev_d[i] = rev_q[i];
      ret_d[i] = ret_q[i];
      zp_d[i]  = zp_q[i];
      // Period boundary uses pre-write state; a same-cycle bus write overrides below.
      if (w_bnd && ch_en_q[i]) begin
        if (zp_q[i]) begin
          fwd_d[i] = '0;
          rev_d[i] = '0;
          cur_d[i] = c_neutral;
          tgt_d[i] = c_neutral;
          zp_d[i]  = 1'b0;
        end else if (ret_q[i] && fwd_q[i] == rev_q[i]) begin
          ret_d[i]   = 1'b0;
          cur_d[i]   = c_neutral;
          tgt_d[i]   = c_neutral;
          set_irq[i] = 1'b1;
        end else begin
          cur_d[i] = slew_next(cur_q[i], tgt_q[i]);
          if (cur_d[i] == c_fwd && fwd_q[i] != '1) fwd_d[i] = fwd_q[i] + 32'd1;
          if (cur_d[i] == c_rev && rev_q[i] != '1) rev_d[i] = rev_q[i] + 32'd1;
        end
      end
      if (w_wr && w_is_ch && w_ch_idx == 7'(i)) begin
        if (w_off == 6'h00) begin
          tgt_d[i] = clamp_pw(apb.PWDATA);
          ret_d[i] = 1'b0;
        end else if (w_off == 6'h04) begin
          case (apb.PWDATA)
            32'd0: begin tgt_d[i] = c_neutral; ret_d[i] = 1'b0; end
            32'd1: begin tgt_d[i] = c_fwd;     ret_d[i] = 1'b0; end
            32'd2: begin tgt_d[i] = c_rev;     ret_d[i] = 1'b0; end
            32'd3: begin tgt_d[i] = c_neutral; ret_d[i] = 1'b0; zp_d[i] = 1'b1; end
            32'd4: begin
              if (!ret_q[i]) begin
                if (fwd_q[i] > rev_q[i]) begin
                  tgt_d[i] = c_rev;
                  ret_d[i] = 1'b1;
                end else if (rev_q[i] > fwd_q[i]) begin
                  tgt_d[i] = c_fwd;
                  ret_d[i] = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
    // A completion in the same cycle as its W1C keeps the bit set.
    if (w_wr && w_addr == 13'h008) irq_stat_d = irq_stat_q & ~apb.PWDATA[NUM_CH-1:0];
    irq_stat_d = irq_stat_d | set_irq;
  end

  always_comb begin
    w_rdata = 32'hFFFF_FFFF;
    if (w_addr == 13'h000) begin
      w_rdata = 32'(ch_en_q);
    end else if (w_addr == 13'h004) begin
      w_rdata = 32'(irq_en_q);
    end else if (w_addr == 13'h008) begin
      w_rdata = 32'(irq_stat_q);
    end else if (w_is_ch && w_off_ok) begin
      w_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ch_idx == 7'(i)) begin
          case (w_off)
            6'h00:   w_rdata = tgt_q[i];
            6'h08:   w_rdata = {29'd0, cur_q[i] == tgt_q[i], zp_q[i], ret_q[i]};
            6'h0C:   w_rdata = fwd_q[i];
            6'h10:   w_rdata = rev_q[i];
            6'h14:   w_rdata = cur_q[i];
            default: w_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      tcnt_q     <= '0;
      ch_en_q    <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      servo_q    <= '0;
      ret_q      <= '0;
      zp_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= c_neutral;
        cur_q[i] <= c_neutral;
        fwd_q[i] <= '0;
        rev_q[i] <= '0;
      end
    end else begin
      tcnt_q     <= w_bnd ? '0 : tcnt_q + 32'd1;
      ch_en_q    <= ch_en_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      ret_q      <= ret_d;
      zp_q       <= zp_d;
      tgt_q      <= tgt_d;
      cur_q      <= cur_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      for (int i = 0; i < NUM_CH; i++) begin
        servo_q[i] <= ch_en_q[i] & (tcnt_q < cur_q[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_servo_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_servo_array
// Brief   : Self-checking bench for apb_servo_array on a shortened period.
// Rev     : 1.0  initial release
// ============================================================================
module tb_apb_servo_array;
  localparam int P    = 200;
  localparam int N    = 30;
  localparam int F    = 40;
  localparam int R    = 20;
  localparam int PMIN = 10;
  localparam int PMAX = 60;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] servo, servo2;
  logic       irq, irq2;
  int         tb_t = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  apb_servo_array_if bus ();
  apb_servo_array_if bus2 ();

  apb_servo_array #(.NUM_CH(4), .PWM_PERIOD(P), .PW_NEUTRAL(N), .PW_FULL_FWD(F),
    .PW_FULL_REV(R), .PW_MIN(PMIN), .PW_MAX(PMAX), .SLEW_STEP(0)) dut (
    .PCLK(clk), .PRESERN(rstn), .apb(bus), .servo_pwm(servo), .irq(irq));

  apb_servo_array #(.NUM_CH(4), .PWM_PERIOD(P), .PW_NEUTRAL(N), .PW_FULL_FWD(F),
    .PW_FULL_REV(R), .PW_MIN(PMIN), .PW_MAX(PMAX), .SLEW_STEP(3)) dut_slew (
    .PCLK(clk), .PRESERN(rstn), .apb(bus2), .servo_pwm(servo2), .irq(irq2));

  always #5 clk = ~clk;

  // Reference period counter: value seen by the DUT during the current cycle.
  always @(posedge clk) tb_t <= !rstn ? 0 : ((tb_t == P - 1) ? 0 : tb_t + 1);

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } vec_t;
  localparam int NV = 26;
  vec_t tbl [NV];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic idle();
    bus.PSEL = 1'b0;  bus.PENABLE = 1'b0;  bus.PWRITE = 1'b0;  bus.PADDR = '0;  bus.PWDATA = '0;
    bus2.PSEL = 1'b0; bus2.PENABLE = 1'b0; bus2.PWRITE = 1'b0; bus2.PADDR = '0; bus2.PWDATA = '0;
  endtask

  task automatic xfer(input bit d2, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic err);
    if (d2) begin
      bus2.PSEL = 1'b1; bus2.PENABLE = 1'b0; bus2.PWRITE = w; bus2.PADDR = a; bus2.PWDATA = wd;
    end else begin
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = wd;
    end
    @(posedge clk); #1;
    if (d2) bus2.PENABLE = 1'b1; else bus.PENABLE = 1'b1;
    #1;
    rdat = d2 ? bus2.PRDATA : bus.PRDATA;
    err  = d2 ? bus2.PSLVERR : bus.PSLVERR;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wr(input bit d2, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] d;
    logic        e;
    xfer(d2, 1'b1, a, wd, d, e);
  endtask

  task automatic rd(input bit d2, input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    logic        e;
    xfer(d2, 1'b0, a, 32'h0, d, e);
    check(nm, d, exp);
  endtask

  task automatic wait_tcnt(input int v);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tb_t != v && n < 2 * P);
    if (tb_t != v) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_tcnt: at %0d, target %0d not reached", tb_t, v);
    end
  endtask

  task automatic wait_bnd(input int k);
    repeat (k) wait_tcnt(0);
  endtask

  // Counts high cycles of ch0 and of any other channel across one full period.
  task automatic measure(output int hi0, output int hi_other);
    wait_tcnt(1);
    hi0 = 0;
    hi_other = 0;
    repeat (P) begin
      if (servo[0]) hi0++;
      if (servo[3:1] != 3'b000) hi_other++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, ho;
    logic [31:0] d;
    logic        e;

    tbl[0]  = '{1'b0, 32'h000, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h004, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'h008, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h100, 32'(N), 1'b0};
    tbl[4]  = '{1'b0, 32'h114, 32'(N), 1'b0};
    tbl[5]  = '{1'b0, 32'h108, 32'h4, 1'b0};
    tbl[6]  = '{1'b0, 32'h10C, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 32'h110, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 32'h1F0, 32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{1'b0, 32'h200, 32'hFFFF_FFFF, 1'b1};
    tbl[10] = '{1'b0, 32'h00C, 32'hFFFF_FFFF, 1'b1};
    tbl[11] = '{1'b1, 32'h140, 32'd5, 1'b0};
    tbl[12] = '{1'b0, 32'h140, 32'(PMIN), 1'b0};
    tbl[13] = '{1'b1, 32'h140, 32'd1000, 1'b0};
    tbl[14] = '{1'b0, 32'h140, 32'(PMAX), 1'b0};
    tbl[15] = '{1'b1, 32'h140, 32'hFFFF_FFFF, 1'b0};
    tbl[16] = '{1'b0, 32'h140, 32'(PMAX), 1'b0};
    tbl[17] = '{1'b1, 32'h140, 32'd45, 1'b0};
    tbl[18] = '{1'b0, 32'h140, 32'd45, 1'b0};
    tbl[19] = '{1'b1, 32'h000, 32'hFF, 1'b0};
    tbl[20] = '{1'b0, 32'h000, 32'hF, 1'b0};
    tbl[21] = '{1'b1, 32'h000, 32'h0, 1'b0};
    tbl[22] = '{1'b1, 32'h1C0, 32'd12, 1'b0};
    tbl[23] = '{1'b0, 32'h1C0, 32'd12, 1'b0};
    tbl[24] = '{1'b0, 32'h154, 32'(N), 1'b0};
    tbl[25] = '{1'b1, 32'h1F0, 32'h1, 1'b1};

    idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset servo_pwm", 32'(servo), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xfer(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].data, d, e);
      if (!tbl[i].wr) check($sformatf("vec%0d rdata", i), d, tbl[i].data);
      check($sformatf("vec%0d pslverr", i), 32'(e), 32'(tbl[i].err));
    end

    // Ch0 only: neutral pulse each period, others silent.
    wr(0, 32'h000, 32'h1);
    measure(h0, ho);
    check("neutral pulse width", 32'(h0), 32'(N));
    check("disabled channels high cycles", 32'(ho), 32'h0);

    // Dead reckoning and hardware return.
    wr(0, 32'h004, 32'h1);
    wait_tcnt(50);
    wr(0, 32'h104, 32'd1);
    wait_bnd(3); wait_tcnt(50);
    rd(0, 32'h10C, 32'd3, "fwd_cnt after 3 fwd periods");
    rd(0, 32'h114, 32'(F), "pw_cur at full fwd");
    wr(0, 32'h104, 32'd2);
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h110, 32'd1, "rev_cnt after 1 rev period");
    wr(0, 32'h104, 32'd4);
    rd(0, 32'h108, 32'h5, "status in_return");
    rd(0, 32'h100, 32'(R), "return target");
    wait_bnd(2); wait_tcnt(50);
    rd(0, 32'h110, 32'd3, "rev_cnt during return");
    check("irq before return done", 32'(irq), 32'h0);
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h114, 32'(N), "pw_cur after return");
    rd(0, 32'h108, 32'h4, "status after return");
    rd(0, 32'h008, 32'h1, "irq_stat after return");
    check("irq after return", 32'(irq), 32'h1);
    rd(0, 32'h10C, 32'd3, "fwd_cnt after return");
    rd(0, 32'h110, 32'd3, "rev_cnt after return");

    // W1C, set-zero, then IRQ set colliding with W1C on the boundary.
    wr(0, 32'h008, 32'h1);
    rd(0, 32'h008, 32'h0, "irq_stat after w1c");
    wr(0, 32'h104, 32'd3);
    rd(0, 32'h108, 32'h6, "status zero_pending");
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h10C, 32'd0, "fwd_cnt after set-zero");
    rd(0, 32'h108, 32'h4, "status after set-zero");
    wr(0, 32'h104, 32'd1);
    wait_bnd(1); wait_tcnt(50);
    wr(0, 32'h104, 32'd4);
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h110, 32'd1, "rev_cnt second return");
    wait_tcnt(P - 2);
    check("irq before collision", 32'(irq), 32'h0);
    wr(0, 32'h008, 32'h1);
    rd(0, 32'h008, 32'h1, "irq_stat set wins over w1c");
    check("irq after collision", 32'(irq), 32'h1);

    // Target write landing in the boundary cycle waits one more period.
    wait_tcnt(P - 2);
    wr(0, 32'h100, 32'd50);
    rd(0, 32'h114, 32'(N), "pw_cur after boundary write");
    rd(0, 32'h100, 32'd50, "target after boundary write");
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h114, 32'd50, "pw_cur one period later");

    fork
      measure(h0, ho);
      begin
        wait_tcnt(1);
        wait_tcnt(60);
        wr(0, 32'h100, 32'd45);
        rd(0, 32'h114, 32'd50, "pw_cur after mid-period write");
      end
    join
    check("pulse unchanged mid-period", 32'(h0), 32'd50);
    measure(h0, ho);
    check("pulse after boundary", 32'(h0), 32'd45);

    // Disabled channel freezes; pending command applies after enable.
    wr(0, 32'h000, 32'h0);
    wr(0, 32'h104, 32'd1);
    wait_tcnt(10);
    check("servo disabled", 32'(servo), 32'h0);
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h114, 32'd45, "pw_cur frozen while disabled");
    rd(0, 32'h108, 32'h0, "status while disabled");
    wr(0, 32'h000, 32'h1);
    wait_bnd(1); wait_tcnt(50);
    rd(0, 32'h114, 32'(F), "pw_cur after enable");
    rd(0, 32'h10C, 32'd2, "fwd_cnt after enable");

    // Reset in the middle of a return.
    wr(0, 32'h104, 32'd4);
    wait_bnd(1); wait_tcnt(10);
    check("servo before reset", 32'(servo), 32'h1);
    check("irq before reset", 32'(irq), 32'h1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("servo after mid-return reset", 32'(servo), 32'h0);
    check("irq after mid-return reset", 32'(irq), 32'h0);
    rstn = 1'b1;
    rd(0, 32'h114, 32'(N), "pw_cur after reset");
    rd(0, 32'h10C, 32'd0, "fwd_cnt after reset");
    rd(0, 32'h110, 32'd0, "rev_cnt after reset");
    rd(0, 32'h108, 32'h4, "status after reset");
    rd(0, 32'h008, 32'h0, "irq_stat after reset");

    // Slew-limited instance: step 3 per period toward 58.
    wr(1, 32'h000, 32'h1);
    wr(1, 32'h100, 32'd58);
    for (int k = 1; k <= 10; k++) begin
      wait_bnd(1); wait_tcnt(50);
      rd(1, 32'h114, (N + 3 * k > 58) ? 32'd58 : 32'(N + 3 * k), $sformatf("slew period %0d", k));
    end
    rd(1, 32'h108, 32'h4, "slew settled status");
    check("slew irq", 32'(irq2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
